// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB initiator: valid/ready command port in, one-cycle response pulse out
// Optional ACCESS timeout abort is enabled with `define APB_REQUESTER_TIMEOUT_EN.
module apb_requester #(
  parameter int ADDWIDTH       = 8,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDWIDTH-1:0]    cmd_addr,
  input  logic [DATAWIDTH-1:0]   cmd_wdata,
  input  logic [DATAWIDTH/8-1:0] cmd_strb,
  output logic                   rsp_valid,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDWIDTH-1:0]    PADDR,
  output logic [DATAWIDTH-1:0]   PWDATA,
  output logic [DATAWIDTH/8-1:0] PSTRB,
  input  logic                   PREADY,
  input  logic [DATAWIDTH-1:0]   PRDATA
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t state, state_nxt;
  logic   done, abort_xfer, accept, to_hit;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  assign PSEL    = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE = (state == S_ACCESS);
  // Ready is combinational from PREADY so a new command can chain into SETUP with no bubble.
  assign cmd_ready = !PRESET && ((state == S_IDLE) || (state == S_ACCESS && PREADY));
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] to_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                              to_cnt <= '0;
    else if (state == S_SETUP)               to_cnt <= '0;
    else if (state == S_ACCESS && !PREADY)   to_cnt <= to_cnt + 1'b1;
  end

  // The edge that would take the count to the limit is the abort edge.
  assign to_hit = (state == S_ACCESS) && !PREADY && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    abort_xfer = 1'b0;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          done      = 1'b1;
          state_nxt = cmd_valid ? S_SETUP : S_IDLE;
        end else if (to_hit) begin
          abort_xfer = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Reads carry zero data and strobes onto the bus.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_write ? cmd_wdata : '0;
      PSTRB  <= cmd_write ? cmd_strb : '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || abort_xfer;
      if (done) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= 1'b0;
      end else if (abort_xfer) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed scoreboard bench for apb_requester
module tb_apb_requester;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  PSTRB;

  apb_requester dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_fail = 0;
  int rsp_count = 0;
  int waits = 0;
  int wcnt;
  logic [32:0] sb[$];
  logic [31:0] mem [0:255];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder with a programmable number of wait states per ACCESS.
  always_comb PREADY = PSEL && PENABLE && (wcnt >= waits);
  assign PRDATA = mem[PADDR];

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wcnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h12345678;
    end else if (PSEL && PENABLE) begin
      if (PREADY) begin
        wcnt <= 0;
        if (PWRITE)
          for (int b = 0; b < 4; b++)
            if (PSTRB[b]) mem[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Response scoreboard: {err, rdata} popped on each pulse.
  always @(negedge PCLK) begin
    if (rsp_valid) begin
      rsp_count++;
      if (sb.size() == 0) chk("sb_depth", 64'(sb.size()), 64'd1);
      else chk("rsp_payload", {31'b0, rsp_err, rsp_rdata}, {31'b0, sb.pop_front()});
    end
  end

  task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [32:0] exp, output int stalls);
    stalls = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    while (!cmd_ready && stalls < 100) begin
      stalls++;
      @(negedge PCLK);
    end
    if (stalls >= 100) chk("accept_timeout", 64'(stalls), 64'd0);
    else sb.push_back(exp);
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    int st, cnt0;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", {PSEL, PENABLE, rsp_valid}, 0);
    @(negedge PCLK) PRESET = 1'b0;
    @(negedge PCLK);
    chk("idle_ready", cmd_ready, 1);

    // Reset during ACCESS drops the transfer
    waits = 1000;
    send(1'b1, 8'h50, 32'h11223344, 4'hF, 33'h0, st);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("mid_access_penable", PENABLE, 1);
    cnt0 = rsp_count;
    #2 PRESET = 1'b1;
    #1;
    chk("async_rst_psel", {PSEL, PENABLE}, 0);
    chk("async_rst_ready", cmd_ready, 0);
    chk("async_rst_bus", {PWRITE, PADDR, PWDATA, PSTRB}, 0);
    chk("async_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    sb.delete();
    @(negedge PCLK);
    PRESET = 1'b0; waits = 0;
    repeat (3) begin
      @(negedge PCLK);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    chk("post_rst_rsp_count", 64'(rsp_count - cnt0), 0);

    // Zero-wait write
    send(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, {1'b0, 32'h0}, st);
    @(negedge PCLK);
    chk("wr_setup", {PSEL, PENABLE, cmd_ready}, 3'b100);
    chk("wr_ctrl", {PWRITE, PSTRB, PADDR, PWDATA}, {1'b1, 4'hF, 8'h10, 32'hDEADBEEF});
    @(negedge PCLK);
    chk("wr_access", {PSEL, PENABLE, rsp_valid}, 3'b110);
    @(negedge PCLK);
    chk("wr_rsp_n3", {rsp_valid, PSEL, PENABLE}, 3'b100);

    // Read with 4 wait states
    waits = 4;
    send(1'b0, 8'h10, 32'hFFFFFFFF, 4'hF, {1'b0, 32'hDEADBEEF}, st);
    @(negedge PCLK);
    chk("rd_setup_bus", {PWRITE, PSTRB, PWDATA}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("rd_penable_held", {PENABLE, rsp_valid}, 2'b10);
    end
    @(negedge PCLK);
    chk("rd_rsp_n7", {rsp_valid, PENABLE}, 2'b10);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge PCLK);
    chk("rd_rdata_hold", {rsp_valid, rsp_rdata}, {1'b0, 32'hDEADBEEF});

    // Back-to-back write then read
    waits = 0;
    send(1'b1, 8'h20, 32'h000000AA, 4'h1, {1'b0, 32'h0}, st);
    cnt0 = rsp_count;
    fork
      send(1'b0, 8'h20, 32'h0, 4'h0, {1'b0, 32'h000000AA}, st);
      begin
        logic [4:0] psel_t, pen_t;
        for (int i = 0; i < 5; i++) begin
          @(negedge PCLK);
          psel_t[4-i] = PSEL;
          pen_t[4-i]  = PENABLE;
        end
        chk("b2b_psel", psel_t, 5'b11110);
        chk("b2b_penable", pen_t, 5'b01010);
      end
    join
    chk("b2b_stalls", 64'(st), 1);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("b2b_rsp_pulses", 64'(rsp_count - cnt0), 2);

    // Stall: second command held while the first waits
    waits = 3;
    send(1'b1, 8'h30, 32'hCAFEF00D, 4'h3, {1'b0, 32'h0}, st);
    cnt0 = rsp_count;
    fork
      send(1'b0, 8'h40, 32'h0, 4'h0, {1'b0, 32'h12345678}, st);
      begin
        @(negedge PCLK);
        chk("stall_setup_addr", PADDR, 8'h30);
        for (int i = 0; i < 4; i++) begin
          @(negedge PCLK);
          chk("stall_access_addr", {PENABLE, PADDR}, {1'b1, 8'h30});
        end
      end
    join
    chk("stall_cycles", 64'(st), 4);
    @(negedge PCLK);
    chk("stall_new_addr", {PSEL, PENABLE, PADDR}, {2'b10, 8'h40});
    repeat (6) @(negedge PCLK);
    chk("stall_single_accept", 64'(rsp_count - cnt0), 2);

`ifdef APB_REQUESTER_TIMEOUT_EN
    waits = 1000;
    send(1'b0, 8'h10, 32'h0, 4'h0, {1'b1, 32'h0}, st);
    @(negedge PCLK);
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      chk("to_access_held", {PENABLE, rsp_valid}, 2'b10);
    end
    @(negedge PCLK);
    chk("to_abort", {rsp_valid, rsp_err, PSEL, PENABLE}, 4'b1100);
    chk("to_rdata", rsp_rdata, 0);
    waits = 0;
    send(1'b0, 8'h10, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF}, st);
    repeat (3) @(negedge PCLK);
    chk("to_recover", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hDEADBEEF});
`endif

    repeat (4) @(negedge PCLK);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
